// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and debounce state encoding for calc_btn_cond
package calc_pkg;

  // Debounce FSM: STABLE waits for the synchronised input to differ,
  // CHANGING counts consecutive differing cycles.
  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } deb_state_t;

  // Default timing for a 100 MHz clock
  localparam int unsigned CLK_HZ              = 100_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;   // 10 ms
  localparam int unsigned REPEAT_DELAY_DEF    = 50_000_000;  // 500 ms
  localparam int unsigned REPEAT_PERIOD_DEF   = 20_000_000;  // 200 ms

  // Calculator button indices into the per-channel vectors
  localparam int unsigned BTN_L   = 0;
  localparam int unsigned BTN_C   = 1;
  localparam int unsigned BTN_R   = 2;
  localparam int unsigned BTN_D   = 3;
  localparam int unsigned NUM_BTN = 4;

  // Larger of two timing constants, used to size the repeat counter
  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus counter/FSM debouncer for one button
module btn_debounce
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_flip
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  deb_state_t    r_state;

  deb_state_t    w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_flip;

  // Synchroniser, counter, stable level and FSM state registers
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_state  <= STABLE;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_flip;
      r_cnt    <= w_cnt_next;
      r_state  <= w_state_next;
    end
  end

  // Next state: count consecutive differing cycles, flip on the last one
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_flip       = 1'b0;
    case (r_state)
      STABLE: begin
        if (r_sync2 != r_stable) begin
          w_cnt_next   = CW'(1);
          w_state_next = CHANGING;
        end
      end
      CHANGING: begin
        if (r_sync2 == r_stable) begin
          w_state_next = STABLE;
        end else if (r_cnt == CNT_LAST) begin
          w_flip       = 1'b1;
          w_state_next = STABLE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: w_state_next = STABLE;
    endcase
  end

  assign o_stable = r_stable;
  assign o_flip   = w_flip;

endmodule

// File: rtl/calc_btn_cond.sv
// rtl/calc_btn_cond.sv - button conditioning, execute strobe and op freeze; CALC_AUTOREPEAT_EN adds held-button repeat
module calc_btn_cond
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic btnu,
  input  logic btnl_raw,
  input  logic btnc_raw,
  input  logic btnr_raw,
  input  logic btnd_raw,
  output logic btnl,
  output logic btnc,
  output logic btnr,
  output logic btnd_pulse,
  output logic btnd_held
);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_flip;
  logic [NUM_BTN-1:0] w_stable_next;
  logic               w_d_rise;
  logic               w_fire;
  logic [2:0]         r_op;
  logic               r_pulse;

  assign w_raw[BTN_L] = btnl_raw;
  assign w_raw[BTN_C] = btnc_raw;
  assign w_raw[BTN_R] = btnr_raw;
  assign w_raw[BTN_D] = btnd_raw;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .i_rst   (btnu),
      .i_raw   (w_raw[g]),
      .o_stable(w_stable[g]),
      .o_flip  (w_flip[g])
    );
  end

  // Value each stable level takes on this edge, so rise/capture line up with btnd_held
  assign w_stable_next = w_stable ^ w_flip;
  assign w_d_rise      = w_flip[BTN_D] & ~w_stable[BTN_D];

`ifdef CALC_AUTOREPEAT_EN
  localparam int unsigned RMAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_first;
  logic          w_hold_on;
  logic          w_rep_fire;

  // btnd stays held across this edge (not rising, not falling)
  assign w_hold_on  = w_stable[BTN_D] & w_stable_next[BTN_D];
  assign w_rep_fire = w_hold_on &
                      (r_rep_first ? (r_rep_cnt == RW'(REPEAT_DELAY))
                                   : (r_rep_cnt == RW'(REPEAT_PERIOD)));

  // Repeat counter: cycles since the last strobe; first gap uses the delay, later gaps the period
  always_ff @(posedge clk) begin
    if (btnu) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if (w_d_rise) begin
      r_rep_cnt   <= RW'(1);
      r_rep_first <= 1'b1;
    end else if (w_hold_on) begin
      if (w_rep_fire) begin
        r_rep_cnt   <= RW'(1);
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end else begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end
  end

  assign w_fire = w_d_rise | w_rep_fire;
`else
  assign w_fire = w_d_rise;
`endif

  // Execute strobe, one cycle per press (plus repeats when enabled)
  always_ff @(posedge clk) begin
    if (btnu) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_fire;
    end
  end

  // Op bits track while execute is released; the rising edge captures, then they hold
  always_ff @(posedge clk) begin
    if (btnu) begin
      r_op <= 3'b000;
    end else if (!w_stable[BTN_D]) begin
      r_op <= {w_stable_next[BTN_R], w_stable_next[BTN_C], w_stable_next[BTN_L]};
    end
  end

  assign btnl       = r_op[0];
  assign btnc       = r_op[1];
  assign btnr       = r_op[2];
  assign btnd_pulse = r_pulse;
  assign btnd_held  = w_stable[BTN_D];

endmodule

// File: doc/calc_btn_cond.md
Name: calc_btn_cond

Overview:
- Input-conditioning stage directly upstream of the calculator accumulator datapath.
- Takes the raw pushbuttons btnl, btnc, btnr and btnd, synchronises and debounces them on clk, and produces two things:
  - clean operation-select levels for the op decoder;
  - a single-cycle execute strobe that replaces the raw btnd edge.
- btnu is not conditioned here. It is the block's synchronous reset, the same signal that clears the accumulator.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive clk cycles a synchronised input must differ from its stable value before the stable value flips. Legal range is >= 2. 10 ms at 100 MHz.
- REPEAT_DELAY, 50000000: cycles btnd must be held stable-high before the first auto-repeat strobe. Used only with CALC_AUTOREPEAT_EN.
- REPEAT_PERIOD, 20000000: cycles between subsequent auto-repeat strobes. Used only with CALC_AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock; all state on posedge.
- btnu  input  1  reset, synchronous, active-high.
- btnl_raw  input  1  raw left button, asynchronous.
- btnc_raw  input  1  raw centre button, asynchronous.
- btnr_raw  input  1  raw right button, asynchronous.
- btnd_raw  input  1  raw down (execute) button, asynchronous.
- btnl  output  1  debounced, frozen op-select bit to the op decoder.
- btnc  output  1  debounced, frozen op-select bit to the op decoder.
- btnr  output  1  debounced, frozen op-select bit to the op decoder.
- btnd_pulse  output  1  one-cycle execute strobe; the accumulator updates on the cycle it is high.
- btnd_held  output  1  debounced btnd level.

Behaviour:
- Reset: while btnu=1 at a posedge, the following are all cleared to 0:
  - both synchroniser flops of every channel;
  - every stable level and every counter;
  - btnl, btnc, btnr, btnd_pulse, btnd_held;
  - the repeat counter.
- Reset takes priority over every other event. Asserting it mid-bounce discards any partial count.
- Synchroniser: each raw input passes through 2 flops, giving sync = raw delayed 2 cycles.
- Per-channel debounce FSM, states STABLE and CHANGING:
  - STABLE, sync == stable: counter = 0; stay in STABLE.
  - STABLE, sync != stable: counter = 1; go to CHANGING.
  - CHANGING, sync == stable (bounce back): counter = 0; return to STABLE; no output change.
  - CHANGING, sync != stable and counter == DEBOUNCE_CYCLES-1: stable flips on this edge; counter = 0; go to STABLE.
  - CHANGING, sync != stable otherwise: counter increments.
- Debounce latency: stable flips exactly DEBOUNCE_CYCLES cycles after sync first differs, so a clean raw step reaches stable after DEBOUNCE_CYCLES+2 cycles.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter never wraps.
- btnd_held equals the btnd channel's stable level.
- btnd_pulse:
  - registered; high for exactly the one cycle in which btnd_held transitions 0->1;
  - rises on the same edge as btnd_held;
  - no pulse on the 1->0 transition.
- Op freeze:
  - while btnd_held=0, btnl/btnc/btnr track their channels' stable levels;
  - on the edge where btnd_held rises, they capture that edge's stable values (including a same-edge op flip);
  - they then hold while btnd_held=1;
  - tracking resumes on the edge after btnd_held falls.
- Consequence of the freeze: op bits are stable across btnd_pulse and cannot change while execute is held.
- Simultaneous flips on several channels in one cycle are each handled independently.
- A raw glitch shorter than DEBOUNCE_CYCLES produces no output change.

Optional Feature:
- Macro: CALC_AUTOREPEAT_EN.
- With the macro defined:
  - a repeat counter starts at the btnd_held rising edge;
  - the first extra btnd_pulse fires REPEAT_DELAY cycles after the initial pulse;
  - further pulses fire every REPEAT_PERIOD cycles while btnd_held stays 1;
  - each pulse is 1 cycle; op bits stay frozen;
  - the counter clears when btnd_held falls or on reset.
- Without the macro: no repeat logic is present, and exactly one pulse is produced per press.

Decomposition:
- Shared package calc_pkg holds:
  - the debounce FSM state encoding (STABLE, CHANGING);
  - default timing constants for 100 MHz: DEBOUNCE 10 ms, REPEAT delay 500 ms, REPEAT period 200 ms;
  - the calculator button-index constants L, C, R, D.
- One sub-module, btn_debounce: synchroniser plus counter plus FSM for a single channel, parameterised by DEBOUNCE_CYCLES. It is instantiated 4 times.
- Edge detection, op freeze and auto-repeat stay in calc_btn_cond.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4; scenario 6 also uses REPEAT_DELAY=8 and REPEAT_PERIOD=3.
1. Reset: hold btnu=1 for 2 cycles with all raw inputs at 1. All outputs read 0 during reset. After release, btnd_held and btnd_pulse rise together 6 cycles later, with btnd_pulse high exactly 1 cycle.
2. Bounce rejection: btnd_raw toggles 1,0,1,0 with 1 cycle each, then returns to 0. btnd_pulse and btnd_held stay 0 throughout.
3. Op freeze:
   - set btnl_raw=1, let it debounce, then press btnd_raw;
   - 2 cycles after btnd_held=1, set btnl_raw=0 and btnr_raw=1;
   - expected: btnl=1, btnr=0 until btnd_held falls; btnl=0, btnr=1 (after debounce) only after that.
4. Release: btnd_raw 1->0 after a stable press. btnd_held falls 6 cycles later and no pulse occurs.
5. Reset mid-count: btnd_raw goes to 1; btnu is pulsed 1 cycle while the counter is at 2. btnd_held rises only 4 cycles after sync re-differs, never earlier.
6. CALC_AUTOREPEAT_EN defined, btnd held for 20 cycles after btnd_held rises:
   - pulses at offsets 0, 8, 11, 14, 17;
   - none after release.
